// File: rtl/to_serial.sv
// Multi-channel serializer: one NO_CH x BW_IN word per handshake becomes NO_CYC
// BW_OUT-bit beats per channel, least-significant chunk first, with ready/valid on both sides.
module to_serial #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 8,
  parameter int BW_OUT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_in,
  output logic                           rdy_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
  output logic                           vld_out,
  input  logic                           rdy_out,
  output logic                           last_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]   data_out
);

  localparam int NO_CYC = BW_IN / BW_OUT;
  localparam int CW     = $clog2(NO_CYC);
  localparam logic [CW-1:0] CNTR_LAST = CW'(NO_CYC - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                       state;
  logic [CW-1:0]                cntr;
  logic [NO_CH-1:0][BW_IN-1:0]  shreg;
  logic                         accept;
  logic                         consume;

  assign vld_out  = (state == SHIFT);
  assign last_out = vld_out && (cntr == CNTR_LAST);
  assign consume  = vld_out && rdy_out;

  // rdy_out feeds rdy_in combinationally so a new word can load on the final
  // beat's edge; this is what removes the bubble between back-to-back words.
  assign rdy_in = !rst && (!vld_out || (rdy_out && last_out));
  assign accept = vld_in && rdy_in;

  always_comb begin
    for (int i = 0; i < NO_CH; i++) begin
      data_out[i] = shreg[i][BW_OUT-1:0];
    end
  end

  // NOTE: every register below uses <= so all updates see the pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cntr  <= '0;
      // NOTE: the shift register is plain flops, not a RAM, so clearing it on reset is cheap and deterministic.
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= data_in;
            cntr  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (consume) begin
            if (cntr != CNTR_LAST) begin
              for (int i = 0; i < NO_CH; i++) begin
                shreg[i] <= shreg[i] >> BW_OUT;
              end
              cntr <= cntr + 1'b1;
            end else if (accept) begin
              shreg <= data_in;
              cntr  <= '0;
            end else begin
              // Explicit wrap: NO_CYC need not be a power of two.
              cntr  <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cntr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_to_serial.sv
// Bench for to_serial: scoreboard of expected beats pushed on accept and popped on consume,
// plus per-scenario inline checks of handshake timing, backpressure, reset and a NO_CYC=3 instance.
module tb_to_serial;

  localparam int NO_CH  = 10;
  localparam int BW_IN  = 8;
  localparam int BW_OUT = 2;
  localparam int NO_CYC = BW_IN / BW_OUT;

  typedef logic [NO_CH-1:0][BW_IN-1:0]  word_t;
  typedef logic [NO_CH-1:0][BW_OUT-1:0] beat_t;
  typedef struct packed {
    beat_t data;
    logic  last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  vld_in = 1'b0;
  logic  rdy_in;
  word_t data_in = '0;
  logic  vld_out;
  logic  rdy_out = 1'b0;
  logic  last_out;
  beat_t data_out;

  logic                 vld_in3 = 1'b0;
  logic                 rdy_in3;
  logic [1:0][11:0]     data_in3 = '0;
  logic                 vld_out3;
  logic                 rdy_out3 = 1'b1;
  logic                 last_out3;
  logic [1:0][3:0]      data_out3;

  always #5 clk = ~clk;

  to_serial #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) u_dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in), .data_in(data_in),
    .vld_out(vld_out), .rdy_out(rdy_out), .last_out(last_out), .data_out(data_out)
  );

  to_serial #(.NO_CH(2), .BW_IN(12), .BW_OUT(4)) u_dut3 (
    .clk(clk), .rst(rst), .vld_in(vld_in3), .rdy_in(rdy_in3), .data_in(data_in3),
    .vld_out(vld_out3), .rdy_out(rdy_out3), .last_out(last_out3), .data_out(data_out3)
  );

  function automatic beat_t beat_of(input word_t w, input int k);
    beat_t b;
    for (int i = 0; i < NO_CH; i++) b[i] = w[i][k*BW_OUT +: BW_OUT];
    return b;
  endfunction

  // One clock: at the negedge, record what the coming edge will accept/consume, then step past the posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (vld_in && rdy_in)
      for (int k = 0; k < NO_CYC; k++) sb.push_back('{data: beat_of(data_in, k), last: (k == NO_CYC-1)});
    if (vld_out && rdy_out) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got beat %h last %b, expected no beat", data_out, last_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.data || last_out !== e.last) begin
          errors++;
          $display("FAIL sb_beat: got %h last %b, expected %h last %b", data_out, last_out, e.data, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_word();
    for (int i = 0; i < NO_CH; i++) data_in[i] = BW_IN'($urandom);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rdy_in !== 1'b0) begin errors++; $display("FAIL reset_rdy_in: got %b expected 0", rdy_in); end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld_out: got %b expected 0", vld_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL reset_last_out: got %b expected 0", last_out); end
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++; if (rdy_in !== 1'b1) begin errors++; $display("FAIL reset_release_rdy_in: got %b expected 1", rdy_in); end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_release_vld_out: got %b expected 0", vld_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
  endtask

  task automatic test_single();
    logic [1:0] e0 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [1:0] e9 [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    randomize_word();
    data_in[0] = 8'hB4;
    data_in[9] = 8'h1E;
    rdy_out = 1'b1;
    vld_in  = 1'b1;
    cycle();
    vld_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL single_vld beat %0d: got %b expected 1", k, vld_out); end
      checks++; if (last_out !== (k == 3)) begin errors++; $display("FAIL single_last beat %0d: got %b expected %b", k, last_out, k == 3); end
      checks++; if (rdy_in !== (k == 3)) begin errors++; $display("FAIL single_rdy_in beat %0d: got %b expected %b", k, rdy_in, k == 3); end
      checks++; if (data_out[0] !== e0[k] || data_out[9] !== e9[k]) begin
        errors++; $display("FAIL single_data beat %0d: got ch0 %0d ch9 %0d expected ch0 %0d ch9 %0d", k, data_out[0], data_out[9], e0[k], e9[k]);
      end
      cycle();
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL single_idle_vld: got %b expected 0", vld_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h00, 8'hFF, 8'hA5};
    logic [1:0] exp [12]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    int   wi;
    logic acc;
    randomize_word();
    data_in[0] = words[0];
    rdy_out = 1'b1;
    vld_in  = 1'b1;
    cycle();
    wi = 1;
    data_in[0] = words[1];
    for (int k = 0; k < 12; k++) begin
      checks++; if (vld_out !== 1'b1 || data_out[0] !== exp[k]) begin
        errors++; $display("FAIL b2b_beat %0d: got vld %b ch0 %0d expected vld 1 ch0 %0d", k, vld_out, data_out[0], exp[k]);
      end
      checks++; if (rdy_in !== last_out || last_out !== (k % 4 == 3)) begin
        errors++; $display("FAIL b2b_rdy_in %0d: got rdy_in %b last %b expected both %b", k, rdy_in, last_out, k % 4 == 3);
      end
      acc = vld_in && rdy_in;
      cycle();
      if (acc) begin
        wi++;
        if (wi < 3) begin
          randomize_word();
          data_in[0] = words[wi];
        end else begin
          vld_in = 1'b0;
        end
      end
    end
    checks++; if (wi != 3 || vld_out !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got accepts %0d vld %b expected 3 and 0", wi, vld_out);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] e0 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    randomize_word();
    data_in[0] = 8'hB4;
    rdy_out = 1'b1;
    vld_in  = 1'b1;
    cycle();
    vld_in = 1'b0;
    cycle();
    rdy_out = 1'b0;
    repeat (3) begin
      #1;
      checks++; if (vld_out !== 1'b1 || data_out[0] !== 2'd1 || last_out !== 1'b0 || rdy_in !== 1'b0) begin
        errors++; $display("FAIL bp_hold: got vld %b ch0 %0d last %b rdy_in %b expected 1 1 0 0", vld_out, data_out[0], last_out, rdy_in);
      end
      cycle();
    end
    rdy_out = 1'b1;
    for (int k = 1; k < 4; k++) begin
      checks++; if (data_out[0] !== e0[k] || last_out !== (k == 3)) begin
        errors++; $display("FAIL bp_resume beat %0d: got ch0 %0d last %b expected %0d %b", k, data_out[0], last_out, e0[k], k == 3);
      end
      cycle();
    end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL bp_idle_vld: got %b expected 0", vld_out); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] e0 [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
    randomize_word();
    data_in[0] = 8'hB4;
    rdy_out = 1'b1;
    vld_in  = 1'b1;
    cycle();
    vld_in = 1'b0;
    cycle();
    sb.delete();
    rst = 1'b1;
    #1;
    checks++; if (vld_out !== 1'b0 || last_out !== 1'b0 || rdy_in !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got vld %b last %b rdy_in %b expected 0 0 0", vld_out, last_out, rdy_in);
    end
    cycle();
    rst = 1'b0;
    #1;
    checks++; if (rdy_in !== 1'b1 || vld_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: got rdy_in %b vld %b expected 1 0", rdy_in, vld_out);
    end
    randomize_word();
    data_in[0] = 8'h6C;
    vld_in = 1'b1;
    cycle();
    vld_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (vld_out !== 1'b1 || data_out[0] !== e0[k]) begin
        errors++; $display("FAIL rstmid_word beat %0d: got vld %b ch0 %0d expected 1 %0d", k, vld_out, data_out[0], e0[k]);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    int    sent = 0;
    int    budget = 0;
    logic  acc;
    logic  stall;
    beat_t held;
    while ((sent < 300 || sb.size() != 0) && budget < 20000) begin
      if (!vld_in && sent < 300 && $urandom_range(0, 3) != 0) begin
        vld_in = 1'b1;
        randomize_word();
      end
      rdy_out = ($urandom_range(0, 2) != 0);
      #1;
      acc   = vld_in && rdy_in;
      stall = vld_out && !rdy_out;
      held  = data_out;
      cycle();
      budget++;
      if (acc) begin
        sent++;
        vld_in = 1'b0;
      end
      if (stall) begin
        checks++; if (vld_out !== 1'b1 || data_out !== held) begin
          errors++; $display("FAIL rand_stall: got vld %b data %h expected 1 %h", vld_out, data_out, held);
        end
      end
    end
    vld_in = 1'b0;
    checks++; if (budget >= 20000 || sb.size() != 0 || sent != 300) begin
      errors++; $display("FAIL rand_drain: got sent %0d pending %0d cycles %0d expected 300 0 <20000", sent, sb.size(), budget);
    end
  endtask

  task automatic test_param();
    logic [3:0] e0 [9] = '{4'hC, 4'hB, 4'hA, 4'hF, 4'hE, 4'hD, 4'h5, 4'hC, 4'h3};
    logic [3:0] e1 [9] = '{4'h3, 4'h2, 4'h1, 4'h6, 4'h5, 4'h4, 4'h9, 4'h8, 4'h7};
    logic       acc;
    int         wi = 0;
    logic [11:0] w0 [3] = '{12'hDEF, 12'h3C5, 12'h000};
    logic [11:0] w1 [3] = '{12'h456, 12'h789, 12'h000};
    rdy_out3 = 1'b1;
    data_in3[0] = 12'hABC;
    data_in3[1] = 12'h123;
    vld_in3 = 1'b1;
    cycle();
    data_in3[0] = w0[0];
    data_in3[1] = w1[0];
    for (int k = 0; k < 9; k++) begin
      checks++; if (vld_out3 !== 1'b1 || data_out3[0] !== e0[k] || data_out3[1] !== e1[k] || last_out3 !== (k % 3 == 2)) begin
        errors++; $display("FAIL param_beat %0d: got vld %b ch0 %h ch1 %h last %b expected 1 %h %h %b",
                           k, vld_out3, data_out3[0], data_out3[1], last_out3, e0[k], e1[k], k % 3 == 2);
      end
      acc = vld_in3 && rdy_in3;
      cycle();
      if (acc) begin
        wi++;
        if (wi == 1) begin
          data_in3[0] = w0[1];
          data_in3[1] = w1[1];
        end else begin
          vld_in3 = 1'b0;
        end
      end
    end
    checks++; if (vld_out3 !== 1'b0 || rdy_in3 !== 1'b1 || wi != 2) begin
      errors++; $display("FAIL param_wrap: got vld %b rdy_in %b accepts %0d expected 0 1 2", vld_out3, rdy_in3, wi);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_param();
    checks++; if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending beats expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
